// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode definitions: fetch FSM states, IR field positions, PC step.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned JADDR_MSB  = 25;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory port and instruction handshake between the fetch unit (master) and its consumers.
interface instr_fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        instr_valid;
    logic        instr_ready;
    logic        pc_load;
    logic [31:0] pc_target;

    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    modport master (
        output mem_req, mem_addr, instr_valid,
        output Opcode, Funct, rs, rt, rd, shamt, imm, jaddr, pc_out, pc_plus4,
        input  mem_ack, mem_rdata, instr_ready, pc_load, pc_target
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid,
        input  Opcode, Funct, rs, rt, rd, shamt, imm, jaddr, pc_out, pc_plus4,
        output mem_ack, mem_rdata, instr_ready, pc_load, pc_target
    );

endinterface

// File: rtl/instr_field_split.sv
// Pure combinational split of a MIPS instruction word into its decode fields.
module instr_field_split
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm,
    output logic [25:0] jaddr
);

    assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
    assign funct  = ir[FUNCT_MSB:FUNCT_LSB];
    assign rs     = ir[RS_MSB:RS_LSB];
    assign rt     = ir[RT_MSB:RT_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign shamt  = ir[SHAMT_MSB:SHAMT_LSB];
    assign imm    = ir[IMM_MSB:0];
    assign jaddr  = ir[JADDR_MSB:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, req/ack word fetch into IR, valid/ready handoff, branch redirects.
// Optional fetch timeout (ERR state, sticky fetch_err) enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                fetch_err,
    instr_fetch_unit_if.master  bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, ir_q, pc_out_q, pend_target_q;
    logic         pend_q;
    logic         timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout_hit = (state_q == REQ) && !bus.mem_ack &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign fetch_err   = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == REQ && !bus.mem_ack && !timeout_hit) cnt_q <= cnt_q + 1'b1;
            else                                               cnt_q <= '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable && !bus.pc_load) state_d = REQ;
            REQ: begin
                if (timeout_hit)      state_d = ERR;
                // A response that races a redirect is dropped and a fresh request follows.
                else if (bus.mem_ack) state_d = (bus.pc_load || pend_q) ? REQ : HOLD;
            end
            HOLD: if (bus.pc_load || bus.instr_ready) state_d = enable ? REQ : IDLE;
`ifdef FETCH_TIMEOUT_EN
            ERR:  state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req     = (state_q == REQ);
        bus.instr_valid = (state_q == HOLD);
        bus.mem_addr    = pc_q;
        bus.pc_out      = pc_out_q;
        bus.pc_plus4    = pc_out_q + PC_STEP;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            pc_out_q      <= RESET_PC;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, HOLD: if (bus.pc_load) pc_q <= word_align(bus.pc_target);
                REQ: begin
                    if (bus.mem_ack) begin
                        if (bus.pc_load) begin
                            pc_q   <= word_align(bus.pc_target);
                            pend_q <= 1'b0;
                        end else if (pend_q) begin
                            pc_q   <= pend_target_q;
                            pend_q <= 1'b0;
                        end else begin
                            ir_q     <= bus.mem_rdata;
                            pc_out_q <= pc_q;
                            pc_q     <= pc_q + PC_STEP;
                        end
                    end else if (bus.pc_load) begin
                        pend_q        <= 1'b1;
                        pend_target_q <= word_align(bus.pc_target);
                    end
                end
                default: ;
            endcase
        end
    end

    instr_field_split u_split (
        .ir     (ir_q),
        .opcode (bus.Opcode),
        .funct  (bus.Funct),
        .rs     (bus.rs),
        .rt     (bus.rt),
        .rd     (bus.rd),
        .shamt  (bus.shamt),
        .imm    (bus.imm),
        .jaddr  (bus.jaddr)
    );

endmodule
